// File: rtl/led_test_pkg.sv
// Shared types and constants for the LED chaser (led_test_core) and its tick generator.
package led_test_pkg;

    localparam int LED_W = 4;
    localparam int CNT_W = 32;

    typedef logic [LED_W-1:0] led_pat_t;

    localparam led_pat_t PAT_RESET = 4'b0001;

    // A pattern is legal only with exactly one bit set; anything else is re-seeded.
    function automatic logic is_onehot(input led_pat_t p);
        return (p != 4'b0000) && ((p & (p - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: pulses tick for one cycle every STEP_CYCLES clocks.
module led_tick_gen
    import led_test_pkg::*;
#(
    parameter logic [CNT_W-1:0] STEP_CYCLES = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal-count detect and wrap.
    always_comb begin
        tick  = (cnt_q == (STEP_CYCLES - 32'd1));
        cnt_d = cnt_q + 32'd1;
        if (tick) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Prescaler register; rst_n is active-high despite its board-pinout name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_test_core.sv
// LED chaser: one-hot pattern stepped by led_tick_gen, registered output with optional inversion.
// Build option: define LED_TEST_BOUNCE_EN for the ping-pong sequence instead of rotate-left.
module led_test_core
    import led_test_pkg::*;
#(
    parameter logic [CNT_W-1:0] STEP_CYCLES    = 32'd50_000_000,
    parameter bit               LED_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [LED_W-1:0] led
);

    localparam led_pat_t LED_RESET = LED_ACTIVE_LOW ? ~PAT_RESET : PAT_RESET;

    logic     tick;
    led_pat_t pat_q;
    led_pat_t pat_d;
    led_pat_t led_q;
    led_pat_t led_d;

    led_tick_gen #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef LED_TEST_BOUNCE_EN
    logic dir_q;
    logic dir_d;

    // Ping-pong stepping; dir turns around at either end of the bar.
    always_comb begin
        pat_d = pat_q;
        dir_d = dir_q;
        if (tick) begin
            if (!is_onehot(pat_q)) begin
                pat_d = PAT_RESET;
            end else if (dir_q) begin
                pat_d = pat_q >> 1;
            end else begin
                pat_d = pat_q << 1;
            end
            if (pat_d == 4'b1000) begin
                dir_d = 1'b1;
            end else if (pat_d == PAT_RESET) begin
                dir_d = 1'b0;
            end else begin
                dir_d = dir_q;
            end
        end else begin
            pat_d = pat_q;
        end
    end

    // Direction register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Rotate-left stepping.
    always_comb begin
        pat_d = pat_q;
        if (tick) begin
            if (!is_onehot(pat_q)) begin
                pat_d = PAT_RESET;
            end else begin
                pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            end
        end else begin
            pat_d = pat_q;
        end
    end
`endif

    // Output polarity applied ahead of the output register.
    always_comb begin
        led_d = LED_ACTIVE_LOW ? ~pat_q : pat_q;
    end

    // Pattern and output registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pat_q <= PAT_RESET;
            led_q <= LED_RESET;
        end else begin
            pat_q <= pat_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_test_core.sv
// Directed bench for led_test_core with STEP_CYCLES=4, active-high and active-low instances.
module tb_led_test_core;

    logic       clk;
    logic       rst_n;
    logic [3:0] led_hi;
    logic [3:0] led_lo;
    int         n_checks;
    int         n_errors;

`ifdef LED_TEST_BOUNCE_EN
    localparam int SEQ_LEN = 6;
    logic [3:0] seq [SEQ_LEN] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
`else
    localparam int SEQ_LEN = 4;
    logic [3:0] seq [SEQ_LEN] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

    led_test_core #(.STEP_CYCLES(32'd4), .LED_ACTIVE_LOW(1'b0)) led_test (
        .clk   (clk),
        .rst_n (rst_n),
        .led   (led_hi)
    );

    led_test_core #(.STEP_CYCLES(32'd4), .LED_ACTIVE_LOW(1'b1)) led_test_al (
        .clk   (clk),
        .rst_n (rst_n),
        .led   (led_lo)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge, then compare both instances on the falling edge.
    task automatic cyc(input string tag, input logic [3:0] exp);
        @(posedge clk);
        @(negedge clk);
        check(tag, led_hi, exp);
        check({tag, "_al"}, led_lo, ~exp);
    endtask

    // Edge k after release (k=0 first) shows seq[(k/4) % SEQ_LEN].
    function automatic logic [3:0] exp_at(input int k);
        return seq[(k / 4) % SEQ_LEN];
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;

        // Reset held for 5 cycles (100 ns).
        for (int i = 0; i < 5; i++) cyc($sformatf("reset_%0d", i), 4'b0001);
        rst_n = 1'b0;

        // Full sequence beyond one period.
        for (int k = 0; k < 4 * SEQ_LEN + 6; k++) cyc($sformatf("step_k%0d", k), exp_at(k));

        // Re-release and advance to the 0100 plateau, then reset mid-sequence.
        rst_n = 1'b1;
        cyc("rerst", 4'b0001);
        rst_n = 1'b0;
        for (int k = 0; k < 9; k++) cyc($sformatf("pre_mid_k%0d", k), exp_at(k));
        rst_n = 1'b1;
        cyc("mid_reset", 4'b0001);
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) cyc($sformatf("post_mid_k%0d", k), exp_at(k));

        // Collision: edge 11 after release consumes a tick (cnt==3 before it).
        rst_n = 1'b1;
        cyc("coll_pre", 4'b0001);
        rst_n = 1'b0;
        for (int k = 0; k < 11; k++) cyc($sformatf("pre_coll_k%0d", k), exp_at(k));
        rst_n = 1'b1;
        cyc("coll_reset", 4'b0001);
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) cyc($sformatf("post_coll_k%0d", k), exp_at(k));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
